// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: FSM encodings, BTB write-queue
// entry layout, default parameters and the sequential-PC helper.
package bru_pkg;

    localparam int unsigned BRU_PC_W              = 32;
    localparam int unsigned BRU_IMM_W             = 32;
    localparam int unsigned BRU_BR_W              = 1;
    localparam int unsigned BRU_WQ_DEPTH_DEF      = 4;
    localparam int unsigned BRU_SQUASH_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        BRU_IDLE     = 2'd0,
        BRU_REDIRECT = 2'd1,
        BRU_SQUASH   = 2'd2
    } bru_state_e;

    typedef struct packed {
        logic [BRU_PC_W-1:0]  pc;
        logic [BRU_IMM_W-1:0] imm;
        logic [BRU_BR_W-1:0]  branch;
    } wq_entry_t;

    // Fall-through address of a 32-bit instruction, wrapping at 2^32.
    function automatic logic [BRU_PC_W-1:0] seq_pc(input logic [BRU_PC_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Pipeline-facing bundle of the branch resolve unit: EX resolution inputs,
// BTB update port and fetch redirect request.
interface branch_resolve_unit_if;
    import bru_pkg::*;

    logic                ex_valid;
    logic                ex_is_branch;
    logic                ex_is_jump;
    logic [BRU_PC_W-1:0] ex_pc;
    logic [BRU_PC_W-1:0] ex_target;
    logic                ex_taken;
    logic                ex_pred_hit;
    logic                ex_pred_taken;
    logic [BRU_PC_W-1:0] ex_pred_target;

    logic                 btb_ready;
    logic                 btb_write;
    logic [BRU_PC_W-1:0]  btb_pc;
    logic [BRU_IMM_W-1:0] btb_imm;
    logic                 btb_branch;

    logic                redirect;
    logic [BRU_PC_W-1:0] redirect_pc;

    modport master (
        output ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_target, ex_taken,
        output ex_pred_hit, ex_pred_taken, ex_pred_target, btb_ready,
        input  btb_write, btb_pc, btb_imm, btb_branch, redirect, redirect_pc
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jump, ex_pc, ex_target, ex_taken,
        input  ex_pred_hit, ex_pred_taken, ex_pred_target, btb_ready,
        output btb_write, btb_pc, btb_imm, btb_branch, redirect, redirect_pc
    );

endinterface

// File: rtl/bru_write_queue.sv
// FIFO of pending BTB updates. A push into a full queue is accepted only when
// the head is popped in the same cycle; otherwise it is dropped and flagged.
module bru_write_queue
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = BRU_WQ_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wq_entry_t push_data,
    input  logic      pop,
    output wq_entry_t head,
    output logic      full,
    output logic      empty,
    output logic      drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    wq_entry_t        mem_r [DEPTH];

    logic pop_ok_s;
    logic push_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign drop      = push & full & ~pop_ok_s;

    // Head is forced to zero while empty so stale storage never leaks out.
    always_comb begin
        head = '0;
        if (empty) begin
            head = '0;
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

    // Entry storage; contents are only observed through the gated head.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (!push_ok_s && pop_ok_s) begin
                count_r <= count_r - CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compares EX outcome with the fetch prediction, redirects
// fetch on a mispredict and queues BTB updates. Perf counters: BRU_PERF_COUNTERS_EN.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned WQ_DEPTH      = BRU_WQ_DEPTH_DEF,
    parameter int unsigned SQUASH_CYCLES = BRU_SQUASH_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_unit_if.slave  bus,
    output logic [31:0]           resolved_cnt,
    output logic [31:0]           mispred_cnt,
    output logic [31:0]           drop_cnt
);

    localparam int unsigned SQ_CNT_W = $clog2(SQUASH_CYCLES + 1);

    bru_state_e           state_r;
    logic                 redirect_r;
    logic [BRU_PC_W-1:0]  redirect_pc_r;
    logic [SQ_CNT_W-1:0]  sq_cnt_r;

    logic      actual_taken_s;
    logic      pred_eff_s;
    logic      accept_s;
    logic      mispred_s;
    logic      mispredict_evt_s;
    logic      enqueue_s;
    logic      wq_pop_s;
    logic      wq_full_s;
    logic      wq_empty_s;
    logic      wq_drop_s;
    wq_entry_t wq_push_data_s;
    wq_entry_t wq_head_s;

    assign actual_taken_s   = bus.ex_is_jump | (bus.ex_is_branch & bus.ex_taken);
    assign pred_eff_s       = bus.ex_pred_hit & bus.ex_pred_taken;
    assign accept_s         = bus.ex_valid & (bus.ex_is_branch | bus.ex_is_jump)
                              & (state_r == BRU_IDLE);
    assign mispred_s        = (actual_taken_s != pred_eff_s)
                              | (actual_taken_s & pred_eff_s
                                 & (bus.ex_pred_target != bus.ex_target));
    assign mispredict_evt_s = accept_s & mispred_s;
    // Only taken flows whose target the BTB does not already hold need an update.
    assign enqueue_s        = accept_s & actual_taken_s
                              & (~bus.ex_pred_hit | (bus.ex_pred_target != bus.ex_target));

    assign wq_push_data_s = '{pc: bus.ex_pc, imm: bus.ex_target, branch: bus.ex_is_branch};
    assign wq_pop_s       = ~wq_empty_s & bus.btb_ready;

    bru_write_queue #(
        .DEPTH (WQ_DEPTH)
    ) u_write_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (enqueue_s),
        .push_data (wq_push_data_s),
        .pop       (wq_pop_s),
        .head      (wq_head_s),
        .full      (wq_full_s),
        .empty     (wq_empty_s),
        .drop      (wq_drop_s)
    );

    assign bus.btb_write   = ~wq_empty_s;
    assign bus.btb_pc      = wq_head_s.pc;
    assign bus.btb_imm     = wq_head_s.imm;
    assign bus.btb_branch  = wq_head_s.branch;
    assign bus.redirect    = redirect_r;
    assign bus.redirect_pc = redirect_pc_r;

    // Redirect/squash sequencer; wrong-path resolutions are ignored until IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= BRU_IDLE;
            redirect_r    <= 1'b0;
            redirect_pc_r <= 32'd0;
            sq_cnt_r      <= {SQ_CNT_W{1'b0}};
        end else begin
            case (state_r)
                BRU_IDLE: begin
                    sq_cnt_r <= {SQ_CNT_W{1'b0}};
                    if (mispredict_evt_s) begin
                        state_r       <= BRU_REDIRECT;
                        redirect_r    <= 1'b1;
                        redirect_pc_r <= actual_taken_s ? bus.ex_target : seq_pc(bus.ex_pc);
                    end else begin
                        state_r       <= BRU_IDLE;
                        redirect_r    <= 1'b0;
                        redirect_pc_r <= redirect_pc_r;
                    end
                end
                BRU_REDIRECT: begin
                    state_r       <= BRU_SQUASH;
                    redirect_r    <= 1'b0;
                    redirect_pc_r <= redirect_pc_r;
                    sq_cnt_r      <= {SQ_CNT_W{1'b0}};
                end
                BRU_SQUASH: begin
                    redirect_r    <= 1'b0;
                    redirect_pc_r <= redirect_pc_r;
                    if (sq_cnt_r == SQ_CNT_W'(SQUASH_CYCLES - 1)) begin
                        state_r  <= BRU_IDLE;
                        sq_cnt_r <= {SQ_CNT_W{1'b0}};
                    end else begin
                        state_r  <= BRU_SQUASH;
                        sq_cnt_r <= sq_cnt_r + SQ_CNT_W'(1);
                    end
                end
                default: begin
                    state_r       <= BRU_IDLE;
                    redirect_r    <= 1'b0;
                    redirect_pc_r <= redirect_pc_r;
                    sq_cnt_r      <= {SQ_CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef BRU_PERF_COUNTERS_EN
    logic [31:0] resolved_cnt_r;
    logic [31:0] mispred_cnt_r;
    logic [31:0] drop_cnt_r;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            resolved_cnt_r <= 32'd0;
            mispred_cnt_r  <= 32'd0;
            drop_cnt_r     <= 32'd0;
        end else begin
            resolved_cnt_r <= accept_s         ? resolved_cnt_r + 32'd1 : resolved_cnt_r;
            mispred_cnt_r  <= mispredict_evt_s ? mispred_cnt_r + 32'd1  : mispred_cnt_r;
            drop_cnt_r     <= wq_drop_s        ? drop_cnt_r + 32'd1     : drop_cnt_r;
        end
    end

    assign resolved_cnt = resolved_cnt_r;
    assign mispred_cnt  = mispred_cnt_r;
    assign drop_cnt     = drop_cnt_r;
`else
    logic unused_drop_s;

    assign unused_drop_s = wq_drop_s;
    assign resolved_cnt  = 32'd0;
    assign mispred_cnt   = 32'd0;
    assign drop_cnt      = 32'd0;
`endif

endmodule
